// File: rtl/sd_card_dat_reader.sv
// sd_card_dat_reader: 4-bit SD DAT block receiver with per-line CRC16 check,
// byte FIFO and an Avalon-MM register slave.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_IDLE       | sd_clk parked low, divider stopped
// S_WAIT_START | sd_clk running, waiting for all-zero start nibble or timeout
// S_DATA       | receiving 2*block_len nibbles, high nibble of each byte first
// S_CRC        | receiving 16 CRC bits per line, MSB first
// S_END        | sampling the end nibble (expected 4'hF)
// S_DONE       | block finished, sd_clk parked low, done flag set
module sd_card_dat_reader #(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [3:0]  sd_dat,
   output logic        sd_clk
);

   localparam int              AW          = $clog2(FIFO_DEPTH);
   localparam logic [7:0]      HALF_RELOAD = 8'(CLK_DIV / 2 - 1);
   localparam logic [AW:0]     FULL_LVL    = FIFO_DEPTH[AW:0];
   localparam logic [AW:0]     LVL_ONE     = 1;
   localparam logic [AW-1:0]   PTR_ONE     = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_START,
      S_DATA,
      S_CRC,
      S_END,
      S_DONE
   } state_t;

   state_t            state;
   logic [3:0]        dat_q;
   logic [7:0]        half_cnt;
   logic [15:0]       wait_cnt;
   logic [10:0]       nib_cnt;
   logic [3:0]        bit_cnt;
   logic [3:0]        byte_hi;
   logic [3:0][15:0]  crc_q;
   logic [3:0][15:0]  crc_nxt;

   logic              done;
   logic [3:0]        crc_err;
   logic              end_err;
   logic              timeout_flag;

   logic [9:0]        block_len;
   logic [15:0]       timeout_val;

   logic [7:0]        mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       level;

   logic              busy;
   logic              wr_en;
   logic              wr_ctrl;
   logic              abort_go;
   logic              start_go;
   logic              flush;
   logic              freeze;
   logic              rise;
   logic              push;
   logic              pop;
   logic              fifo_empty;
   logic [10:0]       nib_load;
   logic [31:0]       status;
   logic              unused_wd;

   assign busy       = (state == S_WAIT_START) || (state == S_DATA) ||
                       (state == S_CRC) || (state == S_END);
   assign wr_en      = chipselect && !write_n;
   assign wr_ctrl    = wr_en && (address == 2'd0);
   assign abort_go   = wr_ctrl && writedata[1];
   assign start_go   = wr_ctrl && writedata[0] && !writedata[1] &&
                       ((state == S_IDLE) || (state == S_DONE));
   assign flush      = abort_go || start_go;
   assign fifo_empty = (level == '0);
   // A full FIFO stalls the card only during the low phase, so sd_clk parks low.
   assign freeze     = (state == S_DATA) && (level == FULL_LVL) && !sd_clk;
   assign rise       = busy && !freeze && !sd_clk && (half_cnt == 8'd0);
   assign push       = rise && (state == S_DATA) && !nib_cnt[0] && !abort_go;
   assign pop        = chipselect && read && (address == 2'd1) && !fifo_empty && !flush;
   assign nib_load   = {block_len, 1'b0} - 11'd1;
   assign status     = {8'd0, 8'(level), 7'd0, fifo_empty, timeout_flag, end_err,
                        crc_err, done, busy};
   assign unused_wd  = ^writedata[31:16];

   // Next CRC16 (x^16+x^12+x^5+1) value for each line given the sampled bit
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         crc_nxt[i] = {crc_q[i][14:0], 1'b0} ^
                      ((crc_q[i][15] ^ dat_q[i]) ? 16'h1021 : 16'h0000);
      end
   end

   // Single input register on the DAT pads
   always_ff @(posedge clk or posedge reset) begin
      if (reset) dat_q <= 4'hF;
      else       dat_q <= sd_dat;
   end

   // sd_clk divider: half-period down-counter, parked low outside a transfer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sd_clk   <= 1'b0;
         half_cnt <= HALF_RELOAD;
      end else if (!busy || abort_go) begin
         sd_clk   <= 1'b0;
         half_cnt <= HALF_RELOAD;
      end else if (!freeze) begin
         if (half_cnt == 8'd0) begin
            sd_clk   <= ~sd_clk;
            half_cnt <= HALF_RELOAD;
         end else begin
            half_cnt <= half_cnt - 8'd1;
         end
      end
   end

   // Block receive FSM with status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         wait_cnt     <= '0;
         nib_cnt      <= '0;
         bit_cnt      <= '0;
         byte_hi      <= '0;
         crc_q        <= '0;
         done         <= 1'b0;
         crc_err      <= '0;
         end_err      <= 1'b0;
         timeout_flag <= 1'b0;
      end else if (abort_go) begin
         state <= S_IDLE;
      end else if (start_go) begin
         state        <= S_WAIT_START;
         wait_cnt     <= '0;
         nib_cnt      <= '0;
         bit_cnt      <= '0;
         crc_q        <= '0;
         done         <= 1'b0;
         crc_err      <= '0;
         end_err      <= 1'b0;
         timeout_flag <= 1'b0;
      end else if (rise) begin
         case (state)
            S_WAIT_START: begin
               if (dat_q == 4'h0) begin
                  state   <= S_DATA;
                  nib_cnt <= nib_load;
               end else if (wait_cnt == timeout_val) begin
                  state        <= S_DONE;
                  done         <= 1'b1;
                  timeout_flag <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            S_DATA: begin
               crc_q <= crc_nxt;
               if (nib_cnt[0]) byte_hi <= dat_q;
               if (nib_cnt == 11'd0) begin
                  state   <= S_CRC;
                  bit_cnt <= 4'd15;
               end else begin
                  nib_cnt <= nib_cnt - 11'd1;
               end
            end
            S_CRC: begin
               crc_q <= crc_nxt;
               if (bit_cnt == 4'd0) begin
                  for (int i = 0; i < 4; i++) crc_err[i] <= |crc_nxt[i];
                  state <= S_END;
               end else begin
                  bit_cnt <= bit_cnt - 4'd1;
               end
            end
            S_END: begin
               end_err <= (dat_q != 4'hF);
               done    <= 1'b1;
               state   <= S_DONE;
            end
            default: state <= state;
         endcase
      end
   end

   // Configuration registers, frozen while a transfer is in progress
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         block_len   <= 10'd512;
         timeout_val <= 16'hFFFF;
      end else if (wr_en && !busy) begin
         if (address == 2'd2) block_len   <= (writedata[9:0] == 10'd0) ? 10'd512 : writedata[9:0];
         if (address == 2'd3) timeout_val <= writedata[15:0];
      end
   end

   // FIFO pointers and fill level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      level <= level + LVL_ONE;
         else if (pop && !push) level <= level - LVL_ONE;
      end
   end

   // FIFO storage, byte completed on its low nibble
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {byte_hi, dat_q};
   end

   // Registered read mux, one cycle of latency
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
      end else begin
         case (address)
            2'd0:    readdata <= status;
            2'd1:    readdata <= fifo_empty ? 32'd0 : {23'd0, 1'b1, mem[rd_ptr]};
            2'd2:    readdata <= {22'd0, block_len};
            default: readdata <= {16'd0, timeout_val};
         endcase
      end
   end

endmodule
